dmem_responder: RTL and testbench

- Data-memory responder that services load/store requests issued by the pipeline's memory stage.
- Operates over a valid/ready request channel and a one-cycle response pulse.
- Access latency is configurable and multi-cycle; a stall output holds the pipeline while an access is outstanding.
- Replaces the single-cycle data memory where realistic memory timing must be modelled; sits between the memory stage and the hazard unit.

---
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
//   req_valid/req_ready   : request handshake (master -> slave / slave -> master)
//   req_write             : 1 = store, 0 = load
//   req_addr              : byte address
//   req_wdata/req_wstrb   : store data and per-byte lane enables
//   resp_valid            : one-cycle response pulse
//   resp_rdata/resp_err   : load data and fault flag, meaningful while resp_valid=1
//   stall_m               : hold request to the hazard unit
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall_m;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall_m
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err, stall_m
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the pipeline memory stage.
// One access outstanding at a time; the access commits (store write / load
// sample) on the edge entering RESP, and the response is a one-cycle pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (memory contents are kept)
//   bus  : slave side of dmem_responder_if (request channel, response, stall_m)
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam bit          DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;

    logic [31:0]        mem [DEPTH];

    logic               c_write;
    logic [31:0]        c_addr;
    logic [31:0]        c_wdata;
    logic [3:0]         c_wstrb;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic               c_fault;
    logic               enter_resp;
    logic [31:0]        rdata_d;
    logic               err_d;

    // Request used at commit: live inputs when the accept edge is also the commit edge
    always_comb begin
        c_write = wr_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_wstrb = wstrb_q;
        if (DIRECT) begin
            c_write = bus.req_write;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
            c_wstrb = bus.req_wstrb;
        end
    end

    // Word decode and fault detection (misaligned or beyond the array)
    always_comb begin
        c_idx   = c_addr[ADDR_WIDTH+1:2];
        c_fault = (c_addr[1:0] != 2'b00) || ((c_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    end

    // Edge that moves the FSM into RESP
    always_comb begin
        enter_resp = 1'b0;
        if (state_q == IDLE) begin
            enter_resp = DIRECT && bus.req_valid;
        end else if (state_q == BUSY) begin
            enter_resp = (cnt_q == '0);
        end
    end

    // Response payload sampled on the commit edge
    always_comb begin
        err_d   = c_fault;
        rdata_d = '0;
        if (!c_write && !c_fault) begin
            rdata_d = mem[c_idx];
        end
    end

    // Storage array: not reset; a store still waiting in BUSY is dropped by rst
    always_ff @(posedge clk) begin
        if (enter_resp && !rst && c_write && !c_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (c_wstrb[b]) begin
                    mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake/response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q    <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        wstrb_q <= bus.req_wstrb;
                        ready_q <= 1'b0;
                        if (DIRECT) begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rdata_d;
                            err_q    <= err_d;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_W'(CNT_INIT);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rdata_d;
                        err_q    <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    ready_q  <= 1'b1;
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    ready_q  <= 1'b1;
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    // Must react to req_valid in the same cycle, so this one is combinational
    assign bus.stall_m    = !rst && (((state_q == IDLE) && bus.req_valid) || (state_q == BUSY));

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 7) driven one at a
// time and checked cycle by cycle against a timing/memory reference model.
module tb_dmem_responder;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk;
    logic        rst;
    logic        req_valid [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wstrb [3];
    logic        ready     [3];
    logic        rvalid    [3];
    logic [31:0] rdata     [3];
    logic        rerr      [3];
    logic        stall     [3];

    logic [31:0] mem_m [3][1024];
    req_t        req_q [$];
    int          n_checks;
    int          n_errors;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : 7;
        dmem_responder_if u_if ();
        assign u_if.req_valid = req_valid[g];
        assign u_if.req_write = req_write[g];
        assign u_if.req_addr  = req_addr[g];
        assign u_if.req_wdata = req_wdata[g];
        assign u_if.req_wstrb = req_wstrb[g];
        assign ready[g]  = u_if.req_ready;
        assign rvalid[g] = u_if.resp_valid;
        assign rdata[g]  = u_if.resp_rdata;
        assign rerr[g]   = u_if.resp_err;
        assign stall[g]  = u_if.stall_m;
        dmem_responder #(.ADDR_WIDTH(10), .LATENCY(L)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 7;
    endfunction

    function automatic req_t mk(input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r.write = w; r.addr = a; r.wdata = d; r.wstrb = s;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   sel;
        r.write = 1'($urandom_range(0, 1));
        r.wdata = $urandom;
        r.wstrb = 4'($urandom_range(0, 15));
        sel     = $urandom_range(0, 9);
        r.addr  = 32'($urandom_range(0, 15)) << 2;
        if (sel == 8)      r.addr = r.addr | 32'($urandom_range(1, 3));
        else if (sel == 9) r.addr = r.addr | (32'h1 << $urandom_range(12, 31));
        return r;
    endfunction

    // Reference behaviour of one access: fault rules, byte-lane stores, load data
    task automatic model_apply(input int k, input req_t r, output logic [31:0] rd, output logic er);
        logic [9:0] idx;
        er  = (r.addr[1:0] != 2'b00) || (r.addr[31:12] != 20'd0);
        rd  = '0;
        idx = r.addr[11:2];
        if (!er) begin
            if (r.write) begin
                for (int b = 0; b < 4; b++)
                    if (r.wstrb[b]) mem_m[k][idx][8*b +: 8] = r.wdata[8*b +: 8];
            end else begin
                rd = mem_m[k][idx];
            end
        end
    endtask

    task automatic drive(input int k, input req_t r, input logic v);
        req_valid[k] = v;
        req_write[k] = r.write;
        req_addr[k]  = r.addr;
        req_wdata[k] = r.wdata;
        req_wstrb[k] = r.wstrb;
    endtask

    // Plays req_q into instance k; b2b keeps req_valid high with the next request
    task automatic run_stream(input int k, input bit b2b);
        int lat, n, idx, gap, resp_cnt, resp_cyc, c, budget;
        bit busy, acc, rv_exp, st_exp;
        req_t cur, fly;
        logic [31:0] ed;
        logic ee;
        lat = lat_of(k); n = req_q.size(); idx = 0; gap = 0; resp_cnt = 0;
        resp_cyc = 0; c = 0; busy = 1'b0; cur = '0; fly = '0;
        budget = n * (lat + 5) + 20;
        @(posedge clk); #1;
        if (n > 0) begin cur = req_q[0]; idx = 1; drive(k, cur, 1'b1); end
        while ((idx < n || req_valid[k] || busy) && c < budget) begin
            @(negedge clk);
            st_exp = busy ? (c < resp_cyc) : req_valid[k];
            rv_exp = busy && (c == resp_cyc);
            acc    = !busy && req_valid[k];
            check($sformatf("k%0d c%0d ready", k, c), 32'(ready[k]), 32'(!busy));
            check($sformatf("k%0d c%0d stall", k, c), 32'(stall[k]), 32'(st_exp));
            check($sformatf("k%0d c%0d rvalid", k, c), 32'(rvalid[k]), 32'(rv_exp));
            if (rvalid[k]) resp_cnt++;
            if (rv_exp) begin
                model_apply(k, fly, ed, ee);
                check($sformatf("k%0d c%0d rdata a=%h", k, c, fly.addr), rdata[k], ed);
                check($sformatf("k%0d c%0d err a=%h", k, c, fly.addr), 32'(rerr[k]), 32'(ee));
                busy = 1'b0;
            end else begin
                check($sformatf("k%0d c%0d rdata idle", k, c), rdata[k], 32'd0);
                check($sformatf("k%0d c%0d err idle", k, c), 32'(rerr[k]), 32'd0);
            end
            @(posedge clk); #1;
            if (acc) begin fly = cur; busy = 1'b1; resp_cyc = c + lat; end
            c++;
            if (acc) begin
                if (b2b && idx < n) begin
                    cur = req_q[idx]; idx++; drive(k, cur, 1'b1);
                end else begin
                    drive(k, cur, 1'b0); gap = $urandom_range(0, 2);
                end
            end else if (!req_valid[k] && !busy && idx < n) begin
                if (gap == 0) begin cur = req_q[idx]; idx++; drive(k, cur, 1'b1); end
                else gap--;
            end
        end
        drive(k, cur, 1'b0);
        check($sformatf("k%0d timeout", k), 32'(c >= budget), 32'd0);
        check($sformatf("k%0d resp count", k), 32'(resp_cnt), 32'(n));
    endtask

    task automatic check_quiet(input int k, input string where);
        check($sformatf("k%0d %s ready", k, where), 32'(ready[k]), 32'd1);
        check($sformatf("k%0d %s stall", k, where), 32'(stall[k]), 32'd0);
        check($sformatf("k%0d %s rvalid", k, where), 32'(rvalid[k]), 32'd0);
        check($sformatf("k%0d %s rdata", k, where), rdata[k], 32'd0);
        check($sformatf("k%0d %s err", k, where), 32'(rerr[k]), 32'd0);
    endtask

    // Reset lands while a store to 0x20 sits in BUSY; the old word must survive
    task automatic reset_mid_store(input int k);
        req_t r;
        req_q.delete();
        r = mk(1'b1, 32'h20, 32'h1111_1111, 4'hF);
        req_q.push_back(r);
        run_stream(k, 1'b0);
        r.wdata = 32'h2222_2222;
        @(posedge clk); #1; drive(k, r, 1'b1);
        @(negedge clk);
        check($sformatf("k%0d rstmid acc ready", k), 32'(ready[k]), 32'd1);
        @(posedge clk); #1; drive(k, r, 1'b0);
        @(negedge clk);
        check($sformatf("k%0d rstmid busy ready", k), 32'(ready[k]), 32'd0);
        check($sformatf("k%0d rstmid busy stall", k), 32'(stall[k]), 32'd1);
        rst = 1'b1;
        #1;
        check_quiet(k, "rstmid");
        @(posedge clk); #1; rst = 1'b0;
        req_q.delete();
        req_q.push_back(mk(1'b0, 32'h20, 32'h0, 4'h0));
        run_stream(k, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) drive(k, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_quiet(k, "in reset");
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) check_quiet(k, "after reset");

        for (int k = 0; k < 3; k++) begin
            req_q.delete();
            for (int w = 0; w < 16; w++) req_q.push_back(mk(1'b1, 32'(w * 4), $urandom, 4'hF));
            run_stream(k, 1'b1);
        end

        req_q.delete();
        req_q.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF));
        req_q.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
        req_q.push_back(mk(1'b1, 32'h10, 32'h0000_00AA, 4'h1));
        req_q.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
        req_q.push_back(mk(1'b0, 32'h12, 32'h0, 4'h0));
        req_q.push_back(mk(1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF));
        req_q.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0));
        req_q.push_back(mk(1'b1, 32'h10, 32'h5555_5555, 4'h0));
        req_q.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
        run_stream(0, 1'b0);

        for (int k = 1; k < 3; k++) begin
            req_q.delete();
            for (int w = 0; w < 8; w++) req_q.push_back(mk(1'b0, 32'(w * 4), 32'h0, 4'h0));
            run_stream(k, 1'b1);
        end

        for (int k = 0; k < 3; k++) begin
            for (int m = 0; m < 2; m++) begin
                req_q.delete();
                for (int i = 0; i < 24; i++) req_q.push_back(rand_req());
                run_stream(k, m[0]);
            end
        end

        reset_mid_store(0);
        reset_mid_store(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
